// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the ALU execute stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: operation codes, FSM state encoding, BCD nibble constants and
// a helper that identifies the ops eligible for decimal adjust.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_ORA = 4'd3,
    OP_EOR = 4'd4,
    OP_ASL = 4'd5,
    OP_LSR = 4'd6,
    OP_ROL = 4'd7,
    OP_ROR = 4'd8,
    OP_INC = 4'd9,
    OP_DEC = 4'd10,
    OP_CMP = 4'd11,
    OP_BIT = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  localparam int BCD_NIBBLE = 4;
  localparam int BCD_LIMIT  = 9;

  // Only add/subtract honour the decimal flag.
  function automatic logic is_bcd_op(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Purpose: combinational BCD add/subtract, nibble by nibble with a decimal carry chain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b      : packed-BCD operands (WIDTH bits, WIDTH a multiple of 4)
//   carry_in  : C flag (carry for add, not-borrow for subtract)
//   subtract  : 0 = A+B+C, 1 = A-B-(1-C)
//   result    : packed-BCD result
//   carry_out : decimal carry (add) / not-borrow (subtract)
module bcd_adjust
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             subtract,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int NIBBLES = WIDTH / BCD_NIBBLE;

  logic       c;
  logic [4:0] s;
  logic [3:0] an;
  logic [3:0] bn;

  always_comb begin
    c      = carry_in;
    s      = '0;
    an     = '0;
    bn     = '0;
    result = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      an = a[i*BCD_NIBBLE +: BCD_NIBBLE];
      bn = b[i*BCD_NIBBLE +: BCD_NIBBLE];
      if (!subtract) begin
        // Digit sum above 9 skips the six unused codes and carries.
        s = {1'b0, an} + {1'b0, bn} + {4'b0, c};
        if (s > 5'(BCD_LIMIT)) begin
          s = s + 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end else begin
        // Bit 4 of the 5-bit difference is the digit borrow.
        s = {1'b0, an} - {1'b0, bn} - {4'b0, ~c};
        if (s[4]) begin
          s = s - 5'd6;
          c = 1'b0;
        end else begin
          c = 1'b1;
        end
      end
      result[i*BCD_NIBBLE +: BCD_NIBBLE] = s[3:0];
    end
    carry_out = c;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: multi-cycle 6502-style ALU stage feeding the status register.
// Latency: start to done 2 cycles (binary), 3 cycles (decimal ADC/SBC).
// Backpressure: start ignored while busy; accepted in IDLE and in the DONE cycle.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   start, op, a_in, b_in         : request and operands (latched on accept)
//   carry_in, overflow_in         : current C / V flags
//   decimal_in                    : D flag (ADC/SBC only)
//   busy, done                    : in-flight indicator, one-cycle completion pulse
//   result, write_result          : registered result, accumulator write enable
//   carry_out, zero_out,
//   negative_out, overflow_out    : registered flags for the status register
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8  // must be a multiple of 4 for BCD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             decimal_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             write_result,
  output logic             carry_out,
  output logic             zero_out,
  output logic             negative_out,
  output logic             overflow_out
);

  localparam int MSB = WIDTH - 1;

  alu_state_t state, state_nxt;

  // Operand latches
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             v_q;
  logic             d_q;

  // Binary flags kept across the adjust cycle
  logic bin_z_q;
  logic bin_n_q;
  logic bin_v_q;

  logic accept;
  logic dec_path;

  // Binary datapath
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] x_res;
  logic             x_c;
  logic             x_z;
  logic             x_n;
  logic             x_v;
  logic             x_wr;

  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;

  assign dec_path = d_q && is_bcd_op(op_q);

  // ---------------- FSM next-state / outputs ----------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = dec_path ? ADJ : DONE;
      end
      ADJ: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Binary execute ----------------
  // One shared adder: ADC uses B, SBC/CMP use ~B; CMP forces carry-in high.
  always_comb begin
    add_b = b_q;
    add_c = c_q;
    if (op_q == OP_SBC || op_q == OP_CMP) add_b = ~b_q;
    if (op_q == OP_CMP) add_c = 1'b1;
    sum = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
  end

  always_comb begin
    x_res = a_q;
    x_c   = c_q;
    x_v   = v_q;
    x_wr  = 1'b0;
    case (op_q)
      OP_ADC, OP_SBC: begin
        x_res = sum[MSB:0];
        x_c   = sum[WIDTH];
        x_v   = (a_q[MSB] == add_b[MSB]) && (sum[MSB] != a_q[MSB]);
        x_wr  = 1'b1;
      end
      OP_CMP: begin
        x_res = sum[MSB:0];
        x_c   = sum[WIDTH];
      end
      OP_AND: begin x_res = a_q & b_q; x_wr = 1'b1; end
      OP_ORA: begin x_res = a_q | b_q; x_wr = 1'b1; end
      OP_EOR: begin x_res = a_q ^ b_q; x_wr = 1'b1; end
      OP_ASL: begin x_res = {a_q[MSB-1:0], 1'b0}; x_c = a_q[MSB]; x_wr = 1'b1; end
      OP_LSR: begin x_res = {1'b0, a_q[MSB:1]};   x_c = a_q[0];   x_wr = 1'b1; end
      OP_ROL: begin x_res = {a_q[MSB-1:0], c_q};  x_c = a_q[MSB]; x_wr = 1'b1; end
      OP_ROR: begin x_res = {c_q, a_q[MSB:1]};    x_c = a_q[0];   x_wr = 1'b1; end
      OP_INC: begin x_res = a_q + WIDTH'(1); x_wr = 1'b1; end
      OP_DEC: begin x_res = a_q - WIDTH'(1); x_wr = 1'b1; end
      OP_BIT: begin
        x_res = a_q & b_q;
        x_v   = b_q[MSB-1];
      end
      default: ;  // unused encodings: pass A, flags through, no write
    endcase
    // BIT takes N from the memory operand rather than the result.
    x_z = (x_res == '0);
    x_n = (op_q == OP_BIT) ? b_q[MSB] : x_res[MSB];
  end

  // ---------------- Decimal adjust ----------------
  bcd_adjust #(.WIDTH(WIDTH)) u_bcd_adjust (
    .a         (a_q),
    .b         (b_q),
    .carry_in  (c_q),
    .subtract  (op_q == OP_SBC),
    .result    (bcd_res),
    .carry_out (bcd_c)
  );

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      v_q          <= 1'b0;
      d_q          <= 1'b0;
      bin_z_q      <= 1'b0;
      bin_n_q      <= 1'b0;
      bin_v_q      <= 1'b0;
      result       <= '0;
      write_result <= 1'b0;
      carry_out    <= 1'b0;
      zero_out     <= 1'b0;
      negative_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        op_q <= op;
        a_q  <= a_in;
        b_q  <= b_in;
        c_q  <= carry_in;
        v_q  <= overflow_in;
        d_q  <= decimal_in;
      end

      if (state == EXEC) begin
        if (dec_path) begin
          // Visible outputs keep the previous op until the adjust completes.
          bin_z_q <= x_z;
          bin_n_q <= x_n;
          bin_v_q <= x_v;
        end else begin
          result       <= x_res;
          write_result <= x_wr;
          carry_out    <= x_c;
          zero_out     <= x_z;
          negative_out <= x_n;
          overflow_out <= x_v;
        end
      end

      if (state == ADJ) begin
        // Z/N/V follow the binary result (NMOS behaviour).
        result       <= bcd_res;
        write_result <= 1'b1;
        carry_out    <= bcd_c;
        zero_out     <= bin_z_q;
        negative_out <= bin_n_q;
        overflow_out <= bin_v_q;
      end
    end
  end

endmodule
